// File: rtl/cus19_pkg.sv
// Shared definitions for the CUS19 data-memory arbiter: FSM encoding,
// starvation limit default and crypto burst-length width.
package cus19_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  localparam int STARVE_LIMIT_DEFAULT = 4;
  localparam int BURST_LEN_W          = 4;

endpackage

// File: rtl/cus19_burst_addr_gen.sv
// Crypto burst address generator: loads base/length on start, steps the
// pointer (wrapping at the top of memory) and flags the final beat.
module cus19_burst_addr_gen
  import cus19_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_i,
  input  logic                   adv_i,
  input  logic [ADDR_W-1:0]      base_i,
  input  logic [BURST_LEN_W-1:0] len_i,
  output logic [ADDR_W-1:0]      ptr_o,
  output logic                   last_o
);

  logic [ADDR_W-1:0]      ptr_q, ptr_d;
  logic [BURST_LEN_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every comb output is defaulted first so no path leaves it unassigned (no latch).
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      ptr_d = base_i;
      cnt_d = len_i;
    end else if (adv_i) begin
      ptr_d = ptr_q + ADDR_W'(1);
      // Hold at zero after the final beat so an idle counter never reads as a long burst.
      if (!last_o) cnt_d = cnt_q - BURST_LEN_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  assign ptr_o  = ptr_q;
  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/cus19_dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU memory stage and a crypto
// burst engine, with a bounded CPU streak so bursts cannot starve.
module cus19_dmem_arbiter
  import cus19_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 11,
  parameter int DATA_WIDTH     = 8,
  parameter int STARVE_LIMIT   = STARVE_LIMIT_DEFAULT
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      cpu_req_in,
  input  logic                      cpu_we_in,
  input  logic [MEM_ADDR_WIDTH-1:0] cpu_addr_in,
  input  logic [DATA_WIDTH-1:0]     cpu_wdata_in,
  output logic                      cpu_gnt_out,
  output logic [DATA_WIDTH-1:0]     cpu_rdata_out,
  output logic                      cpu_rvalid_out,
  input  logic                      cry_start_in,
  input  logic                      cry_we_in,
  input  logic [MEM_ADDR_WIDTH-1:0] cry_base_in,
  input  logic [BURST_LEN_W-1:0]    cry_len_in,
  input  logic [DATA_WIDTH-1:0]     cry_wdata_in,
  output logic                      cry_beat_out,
  output logic [DATA_WIDTH-1:0]     cry_rdata_out,
  output logic                      cry_rvalid_out,
  output logic                      cry_busy_out,
  output logic                      cry_done_out,
  output logic                      mem_rd_out,
  output logic [MEM_ADDR_WIDTH-1:0] mem_rd_addr_out,
  output logic                      mem_wr_out,
  output logic [MEM_ADDR_WIDTH-1:0] mem_wr_addr_out,
  output logic [DATA_WIDTH-1:0]     mem_wr_data_out,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data_in
);

  localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

  arb_state_e                state_q, state_d;
  logic [STREAK_W-1:0]       streak_q, streak_d;
  logic                      cry_we_q;
  logic                      start_accept, cpu_gnt, beat, last_beat;
  logic [MEM_ADDR_WIDTH-1:0] ptr;
  logic [DATA_WIDTH-1:0]     cpu_rdata_q, cry_rdata_q;
  logic                      cpu_rvalid_q, cry_rvalid_q, cry_done_q;

  assign start_accept = (state_q == ST_IDLE) && cry_start_in;

  cus19_burst_addr_gen #(
    .ADDR_W (MEM_ADDR_WIDTH)
  ) u_addr_gen (
    .clk_i  (clk_in),
    .rst_i  (rst_in),
    .load_i (start_accept),
    .adv_i  (beat),
    .base_i (cry_base_in),
    .len_i  (cry_len_in),
    .ptr_o  (ptr),
    .last_o (last_beat)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cry_start_in) state_d = ST_BURST;
      ST_BURST: if (beat && last_beat) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Grants are suppressed while reset is held so nothing touches memory mid-abort.
  always_comb begin
    cpu_gnt         = 1'b0;
    beat            = 1'b0;
    mem_rd_out      = 1'b0;
    mem_rd_addr_out = '0;
    mem_wr_out      = 1'b0;
    mem_wr_addr_out = '0;
    mem_wr_data_out = '0;
    if (!rst_in) begin
      case (state_q)
        ST_IDLE:  cpu_gnt = cpu_req_in;
        ST_BURST: begin
          if (cpu_req_in && (streak_q < STREAK_MAX)) cpu_gnt = 1'b1;
          else                                       beat    = 1'b1;
        end
        default: ;
      endcase
    end
    if (cpu_gnt) begin
      mem_rd_out      = !cpu_we_in;
      mem_rd_addr_out = cpu_we_in ? '0 : cpu_addr_in;
      mem_wr_out      = cpu_we_in;
      mem_wr_addr_out = cpu_we_in ? cpu_addr_in : '0;
      mem_wr_data_out = cpu_we_in ? cpu_wdata_in : '0;
    end else if (beat) begin
      mem_rd_out      = !cry_we_q;
      mem_rd_addr_out = cry_we_q ? '0 : ptr;
      mem_wr_out      = cry_we_q;
      mem_wr_addr_out = cry_we_q ? ptr : '0;
      mem_wr_data_out = cry_we_q ? cry_wdata_in : '0;
    end
  end

  // Streak counts only back-to-back CPU wins inside a burst; any beat or idle CPU clears it.
  always_comb begin
    streak_d = '0;
    if ((state_q == ST_BURST) && cpu_gnt) streak_d = streak_q + STREAK_W'(1);
  end

  // NOTE: only this block's registers are reset; the data memory itself keeps its contents.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      streak_q     <= '0;
      cry_we_q     <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      cry_rvalid_q <= 1'b0;
      cry_rdata_q  <= '0;
      cry_done_q   <= 1'b0;
    end else begin
      streak_q     <= streak_d;
      if (start_accept) cry_we_q <= cry_we_in;
      cpu_rvalid_q <= cpu_gnt && !cpu_we_in;
      if (cpu_gnt && !cpu_we_in) cpu_rdata_q <= mem_rd_data_in;
      cry_rvalid_q <= beat && !cry_we_q;
      if (beat && !cry_we_q) cry_rdata_q <= mem_rd_data_in;
      cry_done_q   <= beat && last_beat;
    end
  end

  assign cpu_gnt_out    = cpu_gnt;
  assign cry_beat_out   = beat;
  assign cry_busy_out   = (state_q == ST_BURST);
  assign cpu_rvalid_out = cpu_rvalid_q;
  assign cpu_rdata_out  = cpu_rdata_q;
  assign cry_rvalid_out = cry_rvalid_q;
  assign cry_rdata_out  = cry_rdata_q;
  assign cry_done_out   = cry_done_q;

endmodule

// File: doc/cus19_dmem_arbiter.md
CUS19_DMEM_ARBITER -- requirements
Module: cus19_dmem_arbiter

Interface
REQ-001 SHALL have parameter MEM_ADDR_WIDTH, default 11, data-memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, data-memory word width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, max consecutive CPU grants while a crypto burst waits.
REQ-004 clk_in  input  1  sole clock, all state on rising edge.
REQ-005 rst_in  input  1  reset, asynchronous, active-high.
REQ-006 cpu_req_in  input  1  CPU pipeline memory-stage access request (LD/ST).
REQ-007 cpu_we_in  input  1  1 = store, 0 = load.
REQ-008 cpu_addr_in  input  MEM_ADDR_WIDTH  CPU access address.
REQ-009 cpu_wdata_in  input  DATA_WIDTH  CPU store data.
REQ-010 cpu_gnt_out  output  1  combinational; CPU access performed this cycle; pipeline stalls while cpu_req_in=1 and cpu_gnt_out=0.
REQ-011 cpu_rdata_out / cpu_rvalid_out  output  DATA_WIDTH / 1  registered load data and its one-cycle valid.
REQ-012 cry_start_in  input  1  crypto engine burst start pulse.
REQ-013 cry_we_in, cry_base_in, cry_len_in  input  1 / MEM_ADDR_WIDTH / 4  burst direction, start address, beats minus one (1..16 beats).
REQ-014 cry_wdata_in  input  DATA_WIDTH  write data for current beat, sampled when cry_beat_out=1.
REQ-015 cry_beat_out  output  1  combinational; crypto beat performed this cycle.
REQ-016 cry_rdata_out / cry_rvalid_out  output  DATA_WIDTH / 1  registered burst read data and valid.
REQ-017 cry_busy_out / cry_done_out  output  1 / 1  burst in progress; one-cycle pulse after last beat.
REQ-018 mem_rd_out, mem_rd_addr_out  output  1 / MEM_ADDR_WIDTH  data-memory read port.
REQ-019 mem_wr_out, mem_wr_addr_out, mem_wr_data_out  output  1 / MEM_ADDR_WIDTH / DATA_WIDTH  data-memory write port.
REQ-020 mem_rd_data_in  input  DATA_WIDTH  combinational read data from data memory.

Function
REQ-021 FSM states IDLE, BURST; IDLE->BURST on cry_start_in in IDLE (captures we, base, len into registers); BURST->IDLE at clock edge ending the last beat.
REQ-022 cry_start_in while BURST SHALL be ignored.
REQ-023 IDLE: cpu_gnt_out = cpu_req_in; cry_beat_out = 0; CPU access in the start cycle is granted normally.
REQ-024 BURST: grant CPU if cpu_req_in=1 and streak < STARVE_LIMIT, streak++; else crypto beat, streak cleared; exactly one grant per cycle.
REQ-025 streak SHALL clear in IDLE and whenever cpu_req_in=0.
REQ-026 Crypto beat: address = current pointer; pointer increments mod 2^MEM_ADDR_WIDTH (2047 wraps to 0); remaining count decrements.
REQ-027 Granted load: mem_rd_out=1 with granted address; mem_rd_data_in registered to owner's rdata output, rvalid high next cycle only.
REQ-028 Granted store: mem_wr_out=1 with granted address/data; write lands at same clock edge.
REQ-029 Ungranted cycle: mem_rd_out=0, mem_wr_out=0, all mem addresses/data 0.
REQ-030 cry_done_out SHALL pulse in the cycle after the last beat, coincident with the final cry_rvalid_out for read bursts.
REQ-031 cry_busy_out = (state == BURST).

Reset
REQ-032 rst_in=1 SHALL force IDLE, clear pointer, count, streak, captured burst fields, and all registered outputs to 0.
REQ-033 Reset mid-burst SHALL abort without cry_done_out; unwritten beats are not performed.
REQ-034 Memory contents are not touched by this block's reset.

Structure
REQ-035 FSM state encoding, STARVE_LIMIT default and burst-length width SHALL live in shared package cus19_pkg.
REQ-036 One sub-module SHALL exist: cus19_burst_addr_gen (pointer load/increment/wrap, beat counter, last-beat flag).

Verification
REQ-037 Solo CPU: store 0x5A @0x010 then load 0x010 -> gnt both cycles, cpu_rdata_out=0x5A with rvalid one cycle after load.
REQ-038 Crypto write burst base 0x7FE, len 3, data 0x11..0x44, no CPU -> writes 0x7FE,0x7FF,0x000,0x001; done pulse after 4th beat.
REQ-039 Contention: CPU requests continuously during 2-beat read burst -> pattern 4 CPU grants, 1 beat, 4 CPU, 1 beat; CPU never stalled outside those beats.
REQ-040 cry_start_in while busy with different base -> ignored; original burst completes unchanged.
REQ-041 rst_in asserted after 2 of 8 write beats -> outputs 0 immediately, no done pulse, only 2 locations modified.
